// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
// Two-master round-robin bus arbiter with split-transaction support.
// Decides which master drives the shared bus mux (M_select). A master whose
// transaction is split by the split-capable slave is parked. Its request is
// ignored until the slave asks for completion, and then ownership is restored
// to it.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   m1_req        master 1 bus request (level)
//   m2_req        master 2 bus request (level)
//   split         one-cycle pulse: current transaction split by slave
//   split_req     split slave ready to complete (level)
//   m1_grant      master 1 owns the bus
//   m2_grant      master 2 owns the bus
//   M_select      bus mux select, 1 = master 1, 0 = master 2
//   split_grant   split slave's request honoured, parked owner restored
//   split_pending a master is parked awaiting split completion
//   split_err     sticky, split pulse seen with no master granted
//
// Optional feature macro: BUS_RR_ARBITER_TENURE_LIMIT_EN
//   When defined, an owner is force-released after MAX_HOLD cycles of
//   tenure if the other master is waiting. RESUME is never preempted.
//   When undefined, an owner keeps the bus until its request drops or a
//   split occurs.

module bus_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m1_req,
  input  logic m2_req,
  input  logic split,
  input  logic split_req,
  output logic m1_grant,
  output logic m2_grant,
  output logic M_select,
  output logic split_grant,
  output logic split_pending,
  output logic split_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M1 = 2'd1,
    GRANT_M2 = 2'd2,
    RESUME   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   parked_m1;
  logic   rr_m1;
  logic   rr_nxt;
  logic   m1_elig;
  logic   m2_elig;
  logic   resume_ok;
  logic   park;
  logic   resume_done;
  logic   err_set;
  logic   hold_expired;
  logic   g1_nxt;
  logic   g2_nxt;

  // Eligibility masks out the parked master's request. parked_m1 names the
  // parked master (1 = M1, 0 = M2) and only matters while split_pending.
  // rr_m1 names the master that wins the next tie.
  always_comb begin
    m1_elig   = m1_req && !(split_pending && parked_m1);
    m2_elig   = m2_req && !(split_pending && !parked_m1);
    resume_ok = split_req && split_pending;
  end

`ifdef BUS_RR_ARBITER_TENURE_LIMIT_EN
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] tenure_cnt;

  // The tenure counter holds the number of cycles the current owner has
  // already held the grant. It loads 1 when a grant starts, so the compare
  // against MAX_HOLD triggers at the end of the MAX_HOLD-th cycle. It
  // saturates, and it restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tenure_cnt <= '0;
    end else if (state_nxt != state) begin
      tenure_cnt <= (state_nxt == GRANT_M1 || state_nxt == GRANT_M2) ?
                    CNT_W'(1) : '0;
    end else if ((state == GRANT_M1 || state == GRANT_M2) &&
                 tenure_cnt != HOLD_LIMIT) begin
      tenure_cnt <= tenure_cnt + CNT_W'(1);
    end
  end

  assign hold_expired = (state == GRANT_M1 || state == GRANT_M2) &&
                        (tenure_cnt == HOLD_LIMIT);
`else
  assign hold_expired = 1'b0;
`endif

  // Next-state arbitration. A release goes straight to the other master
  // without an idle bubble. A pending resume beats any new request. A split
  // pulse has priority over a req drop in the same cycle, so the master is
  // still parked.
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_m1;
    park        = 1'b0;
    resume_done = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        err_set = split;
        if (resume_ok)               state_nxt = RESUME;
        else if (m1_elig && m2_elig) state_nxt = rr_m1 ? GRANT_M1 : GRANT_M2;
        else if (m1_elig)            state_nxt = GRANT_M1;
        else if (m2_elig)            state_nxt = GRANT_M2;
      end
      GRANT_M1: begin
        if (split && !split_pending) begin
          park      = 1'b1;
          rr_nxt    = 1'b0;
          state_nxt = m2_elig ? GRANT_M2 : IDLE;
        end else if (!m1_req) begin
          rr_nxt = 1'b0;
          if (resume_ok)    state_nxt = RESUME;
          else if (m2_elig) state_nxt = GRANT_M2;
          else              state_nxt = IDLE;
        end else if (hold_expired && m2_elig) begin
          rr_nxt    = 1'b0;
          state_nxt = GRANT_M2;
        end
      end
      GRANT_M2: begin
        if (split && !split_pending) begin
          park      = 1'b1;
          rr_nxt    = 1'b1;
          state_nxt = m1_elig ? GRANT_M1 : IDLE;
        end else if (!m2_req) begin
          rr_nxt = 1'b1;
          if (resume_ok)    state_nxt = RESUME;
          else if (m1_elig) state_nxt = GRANT_M1;
          else              state_nxt = IDLE;
        end else if (hold_expired && m1_elig) begin
          rr_nxt    = 1'b1;
          state_nxt = GRANT_M1;
        end
      end
      RESUME: begin
        err_set = split;
        if (!split_req) begin
          resume_done = 1'b1;
          rr_nxt      = !parked_m1;
          if (parked_m1) state_nxt = m2_req ? GRANT_M2 : IDLE;
          else           state_nxt = m1_req ? GRANT_M1 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    g1_nxt = (state_nxt == GRANT_M1) || (state_nxt == RESUME && parked_m1);
    g2_nxt = (state_nxt == GRANT_M2) || (state_nxt == RESUME && !parked_m1);
  end

  // State register and registered outputs. The outputs are taken from the
  // next state, so a grant appears one cycle after its request is sampled.
  // M_select keeps its last value while nobody owns the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_m1         <= 1'b1;
      parked_m1     <= 1'b0;
      m1_grant      <= 1'b0;
      m2_grant      <= 1'b0;
      M_select      <= 1'b1;
      split_grant   <= 1'b0;
      split_pending <= 1'b0;
      split_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_m1       <= rr_nxt;
      m1_grant    <= g1_nxt;
      m2_grant    <= g2_nxt;
      split_grant <= (state_nxt == RESUME);
      if (g1_nxt)      M_select <= 1'b1;
      else if (g2_nxt) M_select <= 1'b0;
      if (park) begin
        split_pending <= 1'b1;
        parked_m1     <= (state == GRANT_M1);
      end else if (resume_done) begin
        split_pending <= 1'b0;
      end
      if (err_set) split_err <= 1'b1;
    end
  end

endmodule
